// File: rtl/mem_sram_ctrl_pkg.sv
// mem_sram_ctrl_pkg: RAM op and FSM state encodings shared with the MEM stage,
// plus store lane/byte-enable helpers.
package mem_sram_ctrl_pkg;
   typedef logic [3:0] ram_op_t;
   localparam ram_op_t MEM_NOP = 4'd0;
   localparam ram_op_t MEM_LB  = 4'd1;
   localparam ram_op_t MEM_LBU = 4'd2;
   localparam ram_op_t MEM_LH  = 4'd3;
   localparam ram_op_t MEM_LHU = 4'd4;
   localparam ram_op_t MEM_LW  = 4'd5;
   localparam ram_op_t MEM_SB  = 4'd6;
   localparam ram_op_t MEM_SH  = 4'd7;
   localparam ram_op_t MEM_SW  = 4'd8;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;
   function automatic logic is_store(input ram_op_t op);
      return op == MEM_SB || op == MEM_SH || op == MEM_SW;
   endfunction
   function automatic logic misaligned(input ram_op_t op, input logic [1:0] off);
      return ((op == MEM_LH || op == MEM_LHU || op == MEM_SH) && off[0]) ||
             ((op == MEM_LW || op == MEM_SW) && off != 2'b00);
   endfunction
   function automatic logic [3:0] store_be_n(input ram_op_t op, input logic [1:0] off);
      return op == MEM_SB ? ~(4'b0001 << off) :
             op == MEM_SH ? (off[1] ? 4'b0011 : 4'b1100) : 4'b0000;
   endfunction
   function automatic logic [31:0] store_lanes(input ram_op_t op, input logic [31:0] d);
      return op == MEM_SB ? {4{d[7:0]}} : op == MEM_SH ? {2{d[15:0]}} : d;
   endfunction
endpackage

// File: rtl/mem_sram_ctrl_if.sv
// mem_sram_ctrl_if: MEM-stage request/completion bundle.
interface mem_sram_ctrl_if;
   logic [3:0]  ramOp_i;
   logic [31:0] ramAddr_i;
   logic [31:0] storeData_i;
   logic        success_o;
   logic [31:0] load_data_o;
   logic        addr_error_o;
   modport master (output ramOp_i, ramAddr_i, storeData_i, input success_o, load_data_o, addr_error_o);
   modport slave  (input ramOp_i, ramAddr_i, storeData_i, output success_o, load_data_o, addr_error_o);
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: little-endian lane select and sign/zero extension of a loaded word.
module mem_load_align
   import mem_sram_ctrl_pkg::*;
(
   input  ram_op_t     op,
   input  logic [1:0]  off,
   input  logic [31:0] raw,
   output logic [31:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = raw[{off, 3'b000} +: 8];
   assign h = off[1] ? raw[31:16] : raw[15:0];
   assign data = op == MEM_LB  ? {{24{b[7]}}, b} :
                 op == MEM_LBU ? {24'h0, b} :
                 op == MEM_LH  ? {{16{h[15]}}, h} :
                 op == MEM_LHU ? {16'h0, h} : raw;
endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: fixed-timing single-port async SRAM bridge for the MEM stage.
// Define MEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module mem_sram_ctrl
   import mem_sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
)(
   input  logic            clk,
   input  logic            rst,
   mem_sram_ctrl_if.slave  bus,
   output logic [19:0]     sram_addr_o,
   output logic [31:0]     sram_data_o,
   input  logic [31:0]     sram_data_i,
   output logic            sram_data_oe,
   output logic [3:0]      sram_be_n_o,
   output logic            sram_ce_n_o,
   output logic            sram_oe_n_o,
   output logic            sram_we_n_o
);
   logic [1:0]  state;
   ram_op_t     op_q;
   logic [1:0]  off_q;
   logic [3:0]  cnt;
   logic        err_q;
   logic        mis;
   logic [31:0] aligned;
   logic        unused_addr;
   assign unused_addr = ^bus.ramAddr_i[31:22];
`ifdef MEM_ALIGN_CHECK_EN
   assign mis = misaligned(bus.ramOp_i, bus.ramAddr_i[1:0]);
   assign bus.addr_error_o = state == S_DONE && err_q;
`else
   assign mis = 1'b0;
   assign bus.addr_error_o = 1'b0;
`endif
   assign bus.success_o = state == S_DONE;
   mem_load_align u_align (.op(op_q), .off(off_q), .raw(sram_data_i), .data(aligned));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         op_q            <= MEM_NOP;
         off_q           <= 2'b00;
         cnt             <= 4'd0;
         err_q           <= 1'b0;
         bus.load_data_o <= 32'h0;
         sram_addr_o     <= 20'h0;
         sram_data_o     <= 32'h0;
         sram_data_oe    <= 1'b0;
         sram_be_n_o     <= 4'hF;
         sram_ce_n_o     <= 1'b1;
         sram_oe_n_o     <= 1'b1;
         sram_we_n_o     <= 1'b1;
      end else begin
         case (state)
            S_IDLE: if (bus.ramOp_i != MEM_NOP) begin
               op_q  <= bus.ramOp_i;
               off_q <= bus.ramAddr_i[1:0];
               err_q <= mis;
               state <= mis ? S_DONE : S_SETUP;
               // a rejected access leaves every SRAM pin untouched
               if (!mis) begin
                  sram_addr_o  <= bus.ramAddr_i[21:2];
                  sram_data_o  <= store_lanes(bus.ramOp_i, bus.storeData_i);
                  sram_be_n_o  <= is_store(bus.ramOp_i) ? store_be_n(bus.ramOp_i, bus.ramAddr_i[1:0]) : 4'b0000;
                  sram_ce_n_o  <= 1'b0;
                  sram_oe_n_o  <= is_store(bus.ramOp_i);
                  sram_data_oe <= is_store(bus.ramOp_i);
               end
            end
            S_SETUP: begin
               sram_we_n_o <= !is_store(op_q);
               cnt         <= 4'(WAIT_CYCLES - 1);
               state       <= S_ACCESS;
            end
            S_ACCESS: if (cnt == 4'd0) begin
               if (!is_store(op_q)) bus.load_data_o <= aligned;
               sram_we_n_o  <= 1'b1;
               sram_ce_n_o  <= 1'b1;
               sram_oe_n_o  <= 1'b1;
               sram_data_oe <= 1'b0;
               state        <= S_DONE;
            end else begin
               cnt <= cnt - 4'd1;
            end
            default: begin
               sram_be_n_o <= 4'hF;
               err_q       <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end
endmodule
